// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, issues held read
// requests to instruction memory and presents fetched instructions to the
// IF/ID register. Taken branches from execute squash the current fetch.
//
// Handshake rules:
//   * fetch_valid/id_ready: an instruction is handed off only in a cycle
//     where fetch_valid && id_ready. While fetch_valid is high and id_ready
//     is low, fetch_pc/fetch_inst/fetch_next_pc are held stable.
//   * imem_read/imem_resp: once imem_read is raised it stays high, with
//     imem_address unchanged, until the single-cycle imem_resp strobe.
//   * redirect: fetch_valid is never high in a cycle where redirect=1.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_address,
   output logic        imem_read,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        id_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_inst,
   output logic [31:0] fetch_next_pc
);

   // REQ : read outstanding for pc, response is bypassed straight out
   // HOLD: response buffered because IF/ID stalled, no read issued
   // DROP: read for pc still outstanding but its data is dead after a
   //       redirect; pending_pc holds where to go once it returns
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pending_pc_q, pending_pc_d;
   logic [31:0] inst_buf_q, inst_buf_d;
   logic [31:0] redirect_tgt;

   // Branch targets are word aligned; low address bits are dropped.
   assign redirect_tgt = {redirect_pc[31:2], 2'b00};

   // The address and PC outputs always reflect the registered pc, so the
   // memory address cannot move while a request is outstanding.
   assign imem_address  = pc_q;
   assign fetch_pc      = pc_q;
   assign fetch_next_pc = pc_q + 32'd4;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         pending_pc_q <= 32'd0;
         inst_buf_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         inst_buf_q   <= inst_buf_d;
      end
   end

   // Next-state and output decode for the fetch controller.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      inst_buf_d   = inst_buf_q;
      imem_read    = 1'b0;
      fetch_valid  = 1'b0;
      fetch_inst   = inst_buf_q;

      case (state_q)
         ST_REQ: begin
            imem_read = 1'b1;
            if (redirect) begin
               if (imem_resp) begin
                  // Response arrived with the flush: discard and refetch.
                  pc_d = redirect_tgt;
               end else begin
                  // Request must complete first; remember the target.
                  pending_pc_d = redirect_tgt;
                  state_d      = ST_DROP;
               end
            end else if (imem_resp) begin
               fetch_valid = 1'b1;
               fetch_inst  = imem_rdata;
               if (id_ready) begin
                  pc_d = pc_q + 32'd4;
               end else begin
                  inst_buf_d = imem_rdata;
                  state_d    = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (redirect) begin
               // Flush wins over a simultaneous accept.
               pc_d    = redirect_tgt;
               state_d = ST_REQ;
            end else begin
               fetch_valid = 1'b1;
               if (id_ready) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = ST_REQ;
               end
            end
         end

         ST_DROP: begin
            imem_read = 1'b1;
            if (redirect) begin
               pending_pc_d = redirect_tgt;
            end
            if (imem_resp) begin
               pc_d    = redirect ? redirect_tgt : pending_pc_q;
               state_d = ST_REQ;
            end
         end

         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A memory model answers every read with a
// word derived from its address; a fetch-stream model predicts the outputs
// each cycle, and hand-computed literals pin key points of the sequence.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h6000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_address;
   logic        imem_read;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        id_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic [31:0] fetch_next_pc;

   logic        mem_stall;
   logic        rst_nxt;

   int n_vec  = 0;
   int n_fail = 0;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_address (imem_address),
      .imem_read    (imem_read),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .id_ready     (id_ready),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .fetch_valid  (fetch_valid),
      .fetch_pc     (fetch_pc),
      .fetch_inst   (fetch_inst),
      .fetch_next_pc(fetch_next_pc)
   );

   // Clock generation.
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory: answers an open read in the same cycle unless stalled.
   always @(negedge clk) begin
      #1;
      if (!rst && imem_read && !mem_stall) begin
         imem_resp  = 1'b1;
         imem_rdata = mem_word(imem_address);
      end else begin
         imem_resp  = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
      end
   end

   // Fetch-stream model: m_pc is the next instruction owed to decode,
   // m_buf means that instruction was fetched and waits for decode,
   // m_squash means the read in flight is dead and m_target follows it.
   logic [31:0] m_pc, m_target, tgt;
   logic        m_buf, m_squash, exp_read, exp_valid;

   // Compare process: check outputs against the model, then advance it.
   always @(negedge clk) begin
      #2;
      if (rst) begin
         m_pc     = RESET_PC;
         m_target = 32'd0;
         m_buf    = 1'b0;
         m_squash = 1'b0;
      end else begin
         exp_read  = !m_buf;
         exp_valid = !redirect && (m_buf || (imem_resp && !m_squash));
         chk("m_imem_read", {31'b0, imem_read}, {31'b0, exp_read});
         if (exp_read) chk("m_imem_address", imem_address, m_pc);
         chk("m_fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_valid});
         if (exp_valid) begin
            chk("m_fetch_pc", fetch_pc, m_pc);
            chk("m_fetch_inst", fetch_inst, mem_word(m_pc));
            chk("m_fetch_next_pc", fetch_next_pc, m_pc + 32'd4);
         end
         tgt = {redirect_pc[31:2], 2'b00};
         if (redirect) begin
            if (m_buf) begin
               m_buf = 1'b0;
               m_pc  = tgt;
            end else if (imem_resp) begin
               m_squash = 1'b0;
               m_pc     = tgt;
            end else begin
               m_squash = 1'b1;
               m_target = tgt;
            end
         end else if (m_buf) begin
            if (id_ready) begin
               m_buf = 1'b0;
               m_pc  = m_pc + 32'd4;
            end
         end else if (imem_resp) begin
            if (m_squash) begin
               m_squash = 1'b0;
               m_pc     = m_target;
            end else if (id_ready) begin
               m_pc = m_pc + 32'd4;
            end else begin
               m_buf = 1'b1;
            end
         end
      end
   end

   task automatic step(input logic idr, input logic rd, input logic [31:0] rpc, input logic st);
      @(negedge clk);
      rst         = rst_nxt;
      id_ready    = idr;
      redirect    = rd;
      redirect_pc = rpc;
      mem_stall   = st;
      #3;
   endtask

   // Directed stimulus with literal expectations.
   initial begin
      rst = 1'b1; rst_nxt = 1'b1;
      id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; mem_stall = 1'b1;
      repeat (3) step(0, 0, 32'd0, 1);

      // First cycle out of reset, response held off.
      rst_nxt = 1'b0;
      step(1, 0, 32'd0, 1);
      chk("rst_read", {31'b0, imem_read}, 32'd1);
      chk("rst_addr", imem_address, 32'h6000_0000);
      chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
      chk("rst_pc", fetch_pc, 32'h6000_0000);
      chk("rst_inst", fetch_inst, 32'd0);

      // Sequential fetch with same-cycle presentation.
      step(1, 0, 32'd0, 0);
      chk("seq0_valid", {31'b0, fetch_valid}, 32'd1);
      chk("seq0_pc", fetch_pc, 32'h6000_0000);
      chk("seq0_inst", fetch_inst, 32'h1357_0420);
      chk("seq0_next", fetch_next_pc, 32'h6000_0004);

      // Backpressure on 0x60000004: three held cycles, then one handoff.
      step(0, 0, 32'd0, 0);
      chk("bp_addr", imem_address, 32'h6000_0004);
      chk("bp_valid", {31'b0, fetch_valid}, 32'd1);
      repeat (3) begin
         step(0, 0, 32'd0, 0);
         chk("hold_read", {31'b0, imem_read}, 32'd0);
         chk("hold_inst", fetch_inst, 32'h1353_0420);
      end
      step(1, 0, 32'd0, 0);
      chk("hold_hand_valid", {31'b0, fetch_valid}, 32'd1);
      chk("hold_hand_pc", fetch_pc, 32'h6000_0004);
      step(1, 0, 32'd0, 1);
      chk("after_hold_addr", imem_address, 32'h6000_0008);
      chk("after_hold_read", {31'b0, imem_read}, 32'd1);
      step(1, 0, 32'd0, 0);
      chk("seq2_pc", fetch_pc, 32'h6000_0008);

      // Redirect in HOLD coinciding with id_ready.
      step(0, 0, 32'd0, 0);
      step(1, 1, 32'h6000_0100, 0);
      chk("hold_redir_valid", {31'b0, fetch_valid}, 32'd0);
      step(1, 0, 32'd0, 1);
      chk("hold_redir_addr", imem_address, 32'h6000_0100);

      // Two redirects while the read is outstanding.
      step(1, 1, 32'h6000_0180, 1);
      chk("drop1_valid", {31'b0, fetch_valid}, 32'd0);
      step(1, 0, 32'd0, 1);
      chk("drop_addr_a", imem_address, 32'h6000_0100);
      step(1, 1, 32'h6000_0200, 1);
      chk("drop_addr_b", imem_address, 32'h6000_0100);
      step(1, 0, 32'd0, 0);
      chk("drop_resp_valid", {31'b0, fetch_valid}, 32'd0);
      step(1, 0, 32'd0, 1);
      chk("drop_next_addr", imem_address, 32'h6000_0200);
      step(1, 0, 32'd0, 0);
      chk("drop_next_pc", fetch_pc, 32'h6000_0200);

      // Redirect with response in REQ, unaligned target.
      step(1, 1, 32'h6000_0043, 0);
      chk("req_redir_valid", {31'b0, fetch_valid}, 32'd0);
      step(1, 0, 32'd0, 1);
      chk("req_redir_addr", imem_address, 32'h6000_0040);
      step(1, 0, 32'd0, 0);
      chk("req_redir_pc", fetch_pc, 32'h6000_0040);

      // In DROP, a redirect arriving with the response wins.
      step(1, 1, 32'h6000_0300, 1);
      step(1, 1, 32'h6000_0400, 0);
      chk("drop_late_valid", {31'b0, fetch_valid}, 32'd0);
      step(1, 0, 32'd0, 1);
      chk("drop_late_addr", imem_address, 32'h6000_0400);

      // Address wrap at the top of memory.
      step(1, 1, 32'hFFFF_FFFF, 0);
      step(1, 0, 32'd0, 0);
      chk("wrap_pc", fetch_pc, 32'hFFFF_FFFC);
      chk("wrap_next", fetch_next_pc, 32'h0000_0000);
      step(1, 0, 32'd0, 1);
      chk("wrap_addr", imem_address, 32'h0000_0000);
      step(1, 0, 32'd0, 0);

      // Reset while a read is outstanding.
      step(1, 0, 32'd0, 1);
      rst_nxt = 1'b1;
      step(1, 0, 32'd0, 1);
      rst_nxt = 1'b0;
      step(1, 0, 32'd0, 1);
      chk("rerst_addr", imem_address, 32'h6000_0000);
      chk("rerst_valid", {31'b0, fetch_valid}, 32'd0);
      step(1, 0, 32'd0, 0);
      chk("rerst_pc", fetch_pc, 32'h6000_0000);
      step(0, 0, 32'd0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage feeding the IF/ID pipeline register. It owns the program counter and issues read requests on the instruction-memory port (read held until response). It presents each fetched instruction with its PC and next-sequential PC to the IF/ID register under a valid/ready handshake. It also squashes in-flight or buffered fetches when the execute stage signals a taken branch.

## Interface
Parameters:
- RESET_PC, 32'h6000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_address  out  32  fetch address, held stable while imem_read=1
- imem_read  out  1  read request, held until imem_resp
- imem_rdata  in  32  instruction word, valid when imem_resp=1
- imem_resp  in  1  one-cycle response strobe
- id_ready  in  1  IF/ID accepts this cycle (its load enable)
- redirect  in  1  taken branch/jump resolved, flush fetch
- redirect_pc  in  32  target address; bits [1:0] ignored (treated as 0)
- fetch_valid  out  1  fetch_pc/fetch_inst/fetch_next_pc valid
- fetch_pc  out  32  PC of presented instruction
- fetch_inst  out  32  presented instruction word
- fetch_next_pc  out  32  fetch_pc + 4 (mod 2^32)

## Operation
- Registers: pc (32), pending_pc (32), inst_buf (32), state (REQ, HOLD, DROP).
- Handoff occurs when fetch_valid && id_ready in the same cycle.
- REQ: imem_read=1, imem_address=pc.
  - redirect=1 (any imem_resp): fetch_valid=0. With imem_resp=1: pc<=redirect_pc, stay REQ. With imem_resp=0: pending_pc<=redirect_pc, go DROP.
  - imem_resp=1 and no redirect: fetch_valid=1, fetch_inst=imem_rdata (combinational bypass), fetch_pc=pc. If id_ready: pc<=pc+4, stay REQ. Else: inst_buf<=imem_rdata, go HOLD.
  - Otherwise: fetch_valid=0, hold.
- HOLD: imem_read=0, fetch_valid=1, fetch_inst=inst_buf, fetch_pc=pc.
  - redirect=1: fetch_valid forced 0, pc<=redirect_pc, go REQ. Redirect has priority over id_ready.
  - id_ready=1: pc<=pc+4, go REQ.
  - Otherwise: hold all outputs stable.
- DROP: imem_read=1, imem_address=pc (the outstanding address, unchanged), fetch_valid=0.
  - redirect=1: pending_pc<=redirect_pc. The latest redirect wins, including one coinciding with imem_resp.
  - imem_resp=1: data discarded, pc<=(redirect ? redirect_pc : pending_pc), go REQ.
- fetch_next_pc = fetch_pc + 4, 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
- imem_rdata is never captured except in REQ with imem_resp=1 and redirect=0.

## Timing
- While rst=1: next state REQ, pc<=RESET_PC, pending_pc<=0, inst_buf<=0. Reset mid-request abandons it; a late imem_resp arriving in REQ is accepted as a response to the RESET_PC request. The memory side is reset with the same rst.
- Outputs in the rst cycle are the decoded REQ/pc values of the prior state. Outputs are guaranteed from the first cycle after rst falls: imem_read=1, imem_address=RESET_PC, fetch_valid=0, fetch_pc=RESET_PC, fetch_inst=0.
- Latency, imem_resp to presentation: 0 cycles (same cycle).
- Throughput: one instruction per memory response. A new request is issued in the cycle after a handoff; there is no dead cycle beyond memory latency.
- The redirect target is requested in the cycle after redirect, or after the dropped response returns.
- fetch_valid never asserts in a cycle where redirect=1.
- imem_address never changes while imem_read=1 and imem_resp=0.

## Test plan
- Reset then sequential fetch, memory 1-cycle latency, id_ready=1: addresses 0x60000000, 0x60000004, 0x60000008 issued. Each instruction presented the cycle its imem_resp arrives, with fetch_next_pc = fetch_pc + 4.
- Backpressure: id_ready=0 when the response for 0x60000004 arrives -> HOLD; fetch_inst stays at the buffered word and imem_read=0 for 3 cycles. Raising id_ready hands off once, then requests 0x60000008.
- Redirect in HOLD with id_ready=1 same cycle: fetch_valid=0 that cycle, no handoff. Next cycle imem_address=redirect_pc=0x60000100.
- Redirect while request outstanding (imem_resp=0), then a second redirect to 0x60000200 before the response: imem_address stays at the old pc. The response is discarded with no fetch_valid. Next request goes to 0x60000200.
- redirect and imem_resp in the same REQ cycle, redirect_pc=0x60000043: data discarded and the next address is 0x60000040.
- Wrap: redirect to 0xFFFFFFFC, then handoff: fetch_next_pc=0x00000000 and the following request goes to 0x00000000.
